jogador_automatico: RTL and testbench

Automatic player for the memory game: it sits on the player side of the game circuit, opposite the game's LED display. It watches the game's `leds` output while the game displays a sequence, and records each LED shown. It then replays the recorded sequence on the game's `chaves` input as timed key presses. It re-records every round until the game signals `acertou` or `errou`, and lets the bench or board run full games unattended.

---
 rtl/jogador_automatico.sv | 203 ++++++++++++++++++++
 tb/tb_jogador_automatico.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - automatic memory-game player: records the LED sequence, replays it as key presses
module jogador_automatico #(
    parameter int MAX_SEQ      = 16,
    parameter int QUIET_CYCLES = 8,
    parameter int HOLD_CYCLES  = 2,
    parameter int GAP_CYCLES   = 3,
    localparam int TW          = $clog2(MAX_SEQ + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [3:0]    leds,
    input  logic          acertou,
    input  logic          errou,
    output logic [3:0]    chaves,
    output logic          gravando,
    output logic          reproduzindo,
    output logic [TW-1:0] tamanho,
    output logic          overflow,
    output logic [3:0]    db_estado
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [3:0] {
        OCIOSO     = 4'h0,
        ESPERA_LED = 4'h1,
        GRAVA      = 4'h2,
        SILENCIO   = 4'h3,
        PRESSIONA  = 4'h4,
        SOLTA      = 4'h5,
        FIM        = 4'hF
    } estado_t;

    estado_t       state_q, state_d;
    logic [3:0]    chaves_q, chaves_d;
    logic [TW-1:0] tamanho_q, tamanho_d;
    logic [TW-1:0] idx_q, idx_d, idx_nxt;
    logic          overflow_q, overflow_d;
    logic [3:0]    last_q, last_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    mem_q [MAX_SEQ];
    logic [3:0]    rd_cur, rd_nxt;
    logic          rec, wr_en;

    assign idx_nxt = idx_q + TW'(1);

    always_comb begin
        rd_cur = '0;
        rd_nxt = '0;
        for (int i = 0; i < MAX_SEQ; i++) begin
            if (idx_q == TW'(i))   rd_cur = mem_q[i];
            if (idx_nxt == TW'(i)) rd_nxt = mem_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        chaves_d   = '0;
        tamanho_d  = tamanho_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        last_d     = last_q;
        quiet_d    = quiet_q;
        hold_d     = hold_q;
        gap_d      = gap_q;
        rec        = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            OCIOSO: begin
                if (enable) begin
                    state_d   = ESPERA_LED;
                    tamanho_d = '0;
                    idx_d     = '0;
                end
            end
            ESPERA_LED: begin
                if (leds != 4'd0) begin
                    rec     = 1'b1;
                    state_d = GRAVA;
                end
            end
            GRAVA: begin
                if (leds == 4'd0) begin
                    state_d = SILENCIO;
                    quiet_d = QW'(1);
                end else if (leds != last_q) begin
                    rec = 1'b1;
                end
            end
            SILENCIO: begin
                if (leds != 4'd0) begin
                    rec     = 1'b1;
                    state_d = GRAVA;
                    quiet_d = '0;
                end else if (quiet_q >= QW'(QUIET_CYCLES - 1)) begin
                    // This sample is the last dark one needed: first press starts next cycle
                    state_d  = PRESSIONA;
                    hold_d   = HW'(1);
                    chaves_d = rd_cur;
                end else if (quiet_q < QW'(QUIET_CYCLES)) begin
                    quiet_d = quiet_q + QW'(1);
                end
            end
            PRESSIONA: begin
                if (hold_q >= HW'(HOLD_CYCLES)) begin
                    state_d = SOLTA;
                    gap_d   = GW'(1);
                end else begin
                    hold_d   = hold_q + HW'(1);
                    chaves_d = rd_cur;
                end
            end
            SOLTA: begin
                if (gap_q >= GW'(GAP_CYCLES)) begin
                    if (idx_nxt < tamanho_q) begin
                        state_d  = PRESSIONA;
                        idx_d    = idx_nxt;
                        hold_d   = HW'(1);
                        chaves_d = rd_nxt;
                    end else begin
                        state_d   = ESPERA_LED;
                        tamanho_d = '0;
                        idx_d     = '0;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            FIM: ;
            default: state_d = OCIOSO;
        endcase

        if (rec) begin
            last_d = leds;
            if (tamanho_q == TW'(MAX_SEQ)) begin
                overflow_d = 1'b1;
            end else begin
                wr_en     = 1'b1;
                tamanho_d = tamanho_q + TW'(1);
            end
        end

        // Overrides are applied last so they cancel any record or expiry decided above
        if (!enable) begin
            state_d    = OCIOSO;
            chaves_d   = '0;
            overflow_d = 1'b0;
            tamanho_d  = '0;
            wr_en      = 1'b0;
        end else if ((acertou || errou) && state_q != OCIOSO) begin
            state_d    = FIM;
            chaves_d   = '0;
            tamanho_d  = tamanho_q;
            overflow_d = overflow_q;
            idx_d      = idx_q;
            wr_en      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= OCIOSO;
            chaves_q   <= '0;
            tamanho_q  <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
            quiet_q    <= '0;
            hold_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            chaves_q   <= chaves_d;
            tamanho_q  <= tamanho_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
            quiet_q    <= quiet_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < MAX_SEQ; i++) begin
            if (wr_en && tamanho_q == TW'(i)) mem_q[i] <= leds;
        end
    end

    assign chaves       = chaves_q;
    assign tamanho      = tamanho_q;
    assign overflow     = overflow_q;
    assign db_estado    = state_q;
    assign gravando     = (state_q == ESPERA_LED) || (state_q == GRAVA) || (state_q == SILENCIO);
    assign reproduzindo = (state_q == PRESSIONA) || (state_q == SOLTA);

endmodule

// File: tb/tb_jogador_automatico.sv
// tb/tb_jogador_automatico.sv - randomized self-checking bench for jogador_automatico
module tb_jogador_automatico;

    localparam int MAX = 4;
    localparam int QC  = 8;
    localparam int HC  = 2;
    localparam int GC  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] leds = 4'd0;
    logic       acertou = 1'b0;
    logic       errou = 1'b0;
    logic [3:0] chaves;
    logic       gravando;
    logic       reproduzindo;
    logic [2:0] tamanho;
    logic       overflow;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] smp_q[$];
    logic [3:0] rec_q[$];
    bit         ovf_m = 1'b0;

    jogador_automatico #(
        .MAX_SEQ(MAX), .QUIET_CYCLES(QC), .HOLD_CYCLES(HC), .GAP_CYCLES(GC)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .leds(leds),
        .acertou(acertou), .errou(errou), .chaves(chaves), .gravando(gravando),
        .reproduzindo(reproduzindo), .tamanho(tamanho), .overflow(overflow),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Model: a nonzero sample is a new entry when the previous sample was dark or different
    task automatic record_phase();
        logic [3:0] prev;
        prev = 4'd0;
        rec_q.delete();
        foreach (smp_q[i]) begin
            leds = smp_q[i];
            if (smp_q[i] != 4'd0 && (prev == 4'd0 || smp_q[i] != prev)) begin
                if (rec_q.size() < MAX) rec_q.push_back(smp_q[i]);
                else ovf_m = 1'b1;
            end
            prev = smp_q[i];
            tick();
            if (i < smp_q.size() - 1) begin
                check_eq("rec_gravando", int'(gravando), 1);
                check_eq("rec_tamanho", int'(tamanho), rec_q.size());
                check_eq("rec_overflow", int'(overflow), int'(ovf_m));
                check_eq("rec_chaves", int'(chaves), 0);
            end
        end
        leds = 4'd0;
        check_eq("rp_start_tamanho", int'(tamanho), rec_q.size());
        check_eq("rp_start_overflow", int'(overflow), int'(ovf_m));
        check_eq("rp_start_reproduzindo", int'(reproduzindo), 1);
    endtask

    task automatic replay_phase();
        foreach (rec_q[k]) begin
            for (int h = 0; h < HC; h++) begin
                check_eq("press_chaves", int'(chaves), int'(rec_q[k]));
                check_eq("press_estado", int'(db_estado), 4);
                leds = 4'($urandom);
                tick();
            end
            for (int g = 0; g < GC; g++) begin
                check_eq("gap_chaves", int'(chaves), 0);
                check_eq("gap_estado", int'(db_estado), 5);
                leds = (k == rec_q.size() - 1 && g == GC - 1) ? 4'd0 : 4'($urandom);
                tick();
            end
        end
        leds = 4'd0;
        check_eq("turn_estado", int'(db_estado), 1);
        check_eq("turn_tamanho", int'(tamanho), 0);
        check_eq("turn_chaves", int'(chaves), 0);
    endtask

    task automatic push_dark(input int n);
        for (int i = 0; i < n; i++) smp_q.push_back(4'd0);
    endtask

    task automatic push_val(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) smp_q.push_back(v);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_chaves", int'(chaves), 0);
        check_eq("rst_gravando", int'(gravando), 0);
        check_eq("rst_reproduzindo", int'(reproduzindo), 0);
        check_eq("rst_tamanho", int'(tamanho), 0);
        check_eq("rst_overflow", int'(overflow), 0);
        check_eq("rst_estado", int'(db_estado), 0);
        reset = 1'b1;
        tick();
        check_eq("idle_estado", int'(db_estado), 0);
        enable = 1'b1;
        tick();
        check_eq("enable_estado", int'(db_estado), 1);

        smp_q.delete(); push_val(4'b0001, 5); push_dark(QC);
        record_phase(); replay_phase();
        smp_q.delete(); push_val(4'b0001, 1); push_dark(1); push_val(4'b0100, 1);
        push_dark(1); push_val(4'b0100, 1); push_dark(QC);
        record_phase(); replay_phase();
        smp_q.delete(); push_val(4'b0010, 1); push_val(4'b1000, 1); push_dark(QC);
        record_phase(); replay_phase();
        smp_q.delete(); push_val(4'b0001, 1); push_val(4'b0010, 1); push_val(4'b0100, 1);
        push_val(4'b1000, 1); push_val(4'b0011, 1); push_dark(QC);
        record_phase(); replay_phase();

        for (int r = 0; r < 30; r++) begin
            int n;
            smp_q.delete();
            push_dark($urandom_range(0, 2));
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                push_val(4'($urandom_range(1, 15)), $urandom_range(1, 3));
                if (j != n - 1) push_dark($urandom_range(0, 2));
            end
            push_dark(QC);
            record_phase(); replay_phase();
        end

        smp_q.delete(); push_val(4'b0001, 1); push_dark(QC);
        record_phase();
        check_eq("win_press", int'(chaves), 1);
        acertou = 1'b1;
        tick();
        acertou = 1'b0;
        check_eq("win_chaves", int'(chaves), 0);
        check_eq("win_estado", int'(db_estado), 15);
        tick();
        check_eq("win_hold_estado", int'(db_estado), 15);
        check_eq("win_overflow", int'(overflow), int'(ovf_m));
        enable = 1'b0;
        tick();
        ovf_m = 1'b0;
        check_eq("dis_estado", int'(db_estado), 0);
        check_eq("dis_overflow", int'(overflow), 0);
        check_eq("dis_tamanho", int'(tamanho), 0);
        check_eq("dis_chaves", int'(chaves), 0);

        enable = 1'b1;
        tick();
        smp_q.delete(); push_val(4'b1000, 2); push_dark(QC);
        record_phase();
        tick();
        tick();
        check_eq("solta_estado", int'(db_estado), 5);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_chaves", int'(chaves), 0);
        check_eq("arst_gravando", int'(gravando), 0);
        check_eq("arst_reproduzindo", int'(reproduzindo), 0);
        check_eq("arst_tamanho", int'(tamanho), 0);
        check_eq("arst_overflow", int'(overflow), 0);
        check_eq("arst_estado", int'(db_estado), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
